// File: rtl/classificar_ativo_paralelo.sv
// Active-node classifier: snapshots the node array on start, then reduces LANES nodes per cycle
// to the min or max criterion among active nodes, reporting value, index and a ready pulse.
module classificar_ativo_paralelo #(
    parameter int unsigned NUM_NA         = 8,
    parameter int unsigned CRITERIO_WIDTH = 5,
    parameter int unsigned LANES          = 2,
    localparam int unsigned IDX_WIDTH     = $clog2(NUM_NA)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               aa_atualizar_in,
    input  logic                               modo_max_in,
    input  logic [NUM_NA-1:0]                  na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0]   na_criterio_in,
    output logic                               ca_ocupado_o,
    output logic                               ca_pronto_o,
    output logic                               ca_valido_o,
    output logic [CRITERIO_WIDTH-1:0]          ca_criterio_geral_out,
    output logic [IDX_WIDTH-1:0]               ca_indice_out
);

    localparam int unsigned PASSES = (NUM_NA + LANES - 1) / LANES;
    localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned NPAD   = PASSES * LANES;

    typedef enum logic [0:0] {StIdle, StScan} estado_t;

    estado_t                            r_estado, w_estado_d;
    logic [NUM_NA-1:0]                  r_ativo;
    logic [NUM_NA*CRITERIO_WIDTH-1:0]   r_criterio;
    logic                               r_modo_max;
    logic [PW-1:0]                      r_passo;
    logic                               r_acc_ok;
    logic [CRITERIO_WIDTH-1:0]          r_acc_crit;
    logic [IDX_WIDTH-1:0]               r_acc_idx;
    logic                               r_pronto;
    logic                               r_valido;
    logic [CRITERIO_WIDTH-1:0]          r_crit_out;
    logic [IDX_WIDTH-1:0]               r_idx_out;

    logic [NPAD-1:0]                    w_ativo_pad;
    logic [CRITERIO_WIDTH-1:0]          w_crit_pad [NPAD];
    logic                               w_cand_ok;
    logic [CRITERIO_WIDTH-1:0]          w_cand_crit;
    logic [IDX_WIDTH-1:0]               w_cand_idx;
    logic                               w_substitui;
    logic                               w_ultimo;
    logic                               w_final_ok;
    logic [CRITERIO_WIDTH-1:0]          w_final_crit;
    logic [IDX_WIDTH-1:0]               w_final_idx;

    // Pad the snapshot to a whole number of lane groups; padding is permanently inactive.
    for (genvar i = 0; i < NPAD; i++) begin : g_pad
        if (i < NUM_NA) begin : g_no
            assign w_ativo_pad[i] = r_ativo[i];
            assign w_crit_pad[i]  = r_criterio[CRITERIO_WIDTH*i +: CRITERIO_WIDTH];
        end else begin : g_vazio
            assign w_ativo_pad[i] = 1'b0;
            assign w_crit_pad[i]  = '0;
        end
    end

    // Lanes are visited in ascending index with a strict compare, so ties keep the lowest index.
    always_comb begin
        w_cand_ok   = 1'b0;
        w_cand_crit = '0;
        w_cand_idx  = '0;
        for (int g = 0; g < int'(PASSES); g++) begin
            if (r_passo == PW'(g)) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (w_ativo_pad[g*LANES+l] &&
                        (!w_cand_ok ||
                         (r_modo_max ? (w_crit_pad[g*LANES+l] > w_cand_crit)
                                     : (w_crit_pad[g*LANES+l] < w_cand_crit)))) begin
                        w_cand_ok   = 1'b1;
                        w_cand_crit = w_crit_pad[g*LANES+l];
                        w_cand_idx  = IDX_WIDTH'(g*LANES+l);
                    end
                end
            end
        end
    end

    always_comb begin
        w_substitui  = w_cand_ok &&
                       (!r_acc_ok ||
                        (r_modo_max ? (w_cand_crit > r_acc_crit) : (w_cand_crit < r_acc_crit)));
        w_ultimo     = (r_passo == PW'(PASSES - 1));
        w_final_ok   = w_substitui ? 1'b1        : r_acc_ok;
        w_final_crit = w_substitui ? w_cand_crit : r_acc_crit;
        w_final_idx  = w_substitui ? w_cand_idx  : r_acc_idx;
    end

    always_comb begin
        w_estado_d = r_estado;
        unique case (r_estado)
            StIdle: if (aa_atualizar_in) w_estado_d = StScan;
            StScan: begin
                if (aa_atualizar_in) begin
                    w_estado_d = StScan;
                end else if (w_ultimo) begin
                    w_estado_d = StIdle;
                end
            end
            default: w_estado_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= StIdle;
        end else begin
            r_estado <= w_estado_d;
        end
    end

    // A start on any edge takes priority, which also discards an in-flight or completing scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ativo    <= '0;
            r_criterio <= '0;
            r_modo_max <= 1'b0;
            r_passo    <= '0;
            r_acc_ok   <= 1'b0;
            r_acc_crit <= '0;
            r_acc_idx  <= '0;
            r_pronto   <= 1'b0;
            r_valido   <= 1'b0;
            r_crit_out <= '1;
            r_idx_out  <= '0;
        end else begin
            r_pronto <= 1'b0;
            if (aa_atualizar_in) begin
                r_ativo    <= na_ativo_in;
                r_criterio <= na_criterio_in;
                r_modo_max <= modo_max_in;
                r_passo    <= '0;
                r_acc_ok   <= 1'b0;
                r_acc_crit <= '0;
                r_acc_idx  <= '0;
            end else if (r_estado == StScan) begin
                if (w_ultimo) begin
                    r_pronto   <= 1'b1;
                    r_valido   <= w_final_ok;
                    r_crit_out <= w_final_ok ? w_final_crit : (r_modo_max ? '0 : '1);
                    r_idx_out  <= w_final_ok ? w_final_idx : '0;
                end else begin
                    r_passo    <= r_passo + PW'(1);
                    r_acc_ok   <= w_final_ok;
                    r_acc_crit <= w_final_crit;
                    r_acc_idx  <= w_final_idx;
                end
            end
        end
    end

    assign ca_ocupado_o          = (r_estado == StScan);
    assign ca_pronto_o           = r_pronto;
    assign ca_valido_o           = r_valido;
    assign ca_criterio_geral_out = r_crit_out;
    assign ca_indice_out         = r_idx_out;

endmodule

// File: doc/classificar_ativo_paralelo.md
Name: classificar_ativo_paralelo

Overview:
Parametrised successor to the sequential active-node classifier. On a start pulse it snapshots the active mask and per-node criteria. It scans LANES nodes per cycle and reduces them to the extreme (min or max, selectable per run) criterion among active nodes. It reports the winner's value and index, whether any node was active, and a one-cycle ready pulse. It sits between the node array (NA) and the update controller (AA), which consumes the general criterion.

Parameters:
NUM_NA, 8, number of nodes scanned (>=2).
CRITERIO_WIDTH, 5, bits per node criterion.
LANES, 2, nodes compared per cycle (1..NUM_NA); need not divide NUM_NA.
Derived: IDX_WIDTH = $clog2(NUM_NA); PASSES = ceil(NUM_NA/LANES); pass counter width = max(1, $clog2(PASSES)).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
aa_atualizar_in  input  1  start pulse; sampled every edge.
modo_max_in  input  1  0 = select minimum, 1 = select maximum; sampled with start.
na_ativo_in  input  NUM_NA  active mask; bit i = node i.
na_criterio_in  input  NUM_NA*CRITERIO_WIDTH  node i at [CRITERIO_WIDTH*i+CRITERIO_WIDTH-1 : CRITERIO_WIDTH*i].
ca_ocupado_o  output  1  scan in progress.
ca_pronto_o  output  1  one-cycle pulse: new result on outputs.
ca_valido_o  output  1  at least one node was active in the last completed scan.
ca_criterio_geral_out  output  CRITERIO_WIDTH  winning criterion.
ca_indice_out  output  IDX_WIDTH  winning node index.

Behaviour:
- Reset (async, immediate): ca_ocupado_o=0, ca_pronto_o=0, ca_valido_o=0, ca_criterio_geral_out=all ones, ca_indice_out=0. Internal accumulator, pass counter and snapshot are cleared. Any scan in flight is dropped and produces no pronto.
- States: IDLE, SCAN.
- IDLE -> SCAN on an edge with aa_atualizar_in=1 (edge E0).
  - Snapshot na_ativo_in, na_criterio_in and modo_max_in.
  - Pass counter = 0; accumulator invalid; ca_ocupado_o=1.
  - Inputs may change after E0 without effect.
- SCAN, pass k (edges E1..EPASSES):
  - Combinationally reduce snapshot nodes k*LANES .. k*LANES+LANES-1. Indices >= NUM_NA are treated as inactive.
  - Merge the reduced candidate into the accumulator.
- Merge rule: a candidate replaces the accumulator if it is active and either (accumulator invalid) or (min mode: cand < acc; max mode: cand > acc).
  - The comparison is strict, so on ties the lowest index wins, both within a lane group and across passes.
  - Comparisons are unsigned.
- At edge EPASSES (the last pass), registered outputs are loaded and the state returns to IDLE:
  - ca_criterio_geral_out and ca_indice_out take the winner;
  - ca_valido_o=1;
  - ca_pronto_o=1 for exactly one cycle;
  - ca_ocupado_o=0.
- Latency: pronto rises PASSES cycles after the start edge. Back-to-back starts are accepted in the cycle pronto is high.
- No active node: ca_valido_o=0, ca_indice_out=0, ca_criterio_geral_out = all ones (min mode) or all zeros (max mode). Pronto is still pulsed.
- Outputs hold the previous result for the whole scan and change only at the completion edge.
- Start while in SCAN: abort the current scan, re-snapshot, restart from pass 0. The aborted scan produces no pronto. ca_ocupado_o stays 1.
- Start on the completion edge: the completion is discarded (outputs not updated, no pronto) and the new scan begins.
- Pronto is deasserted on any edge where it is not a completion.
- LANES=NUM_NA: PASSES=1, so the result arrives one cycle after start.

Test Plan:
1. NUM_NA=8, LANES=2, min mode, ativo=8'hFF, criteria node0..7 = {7,3,9,3,12,5,3,30}, pulse start -> ca_ocupado_o high for 4 cycles; pronto one cycle 4 edges after start; criterio=3, indice=1, valido=1.
2. Same data with modo_max_in=1 -> criterio=30, indice=7, valido=1; pronto again after 4 cycles.
3. ativo=8'h00 in min mode -> valido=0, criterio=5'h1F, indice=0, pronto pulsed once. Repeat in max mode -> criterio=0.
4. Start scan A, re-pulse start 2 cycles later with ativo=8'h10 and node4=6 -> exactly one pronto, 4 cycles after the second start; criterio=6, indice=4. Change inputs during the scan and check the result is unchanged.
5. Assert rst_n=0 mid-scan after a prior result of 3 -> outputs immediately take reset values, no pronto. After release, idle until the next start.
6. NUM_NA=8, LANES=3 (PASSES=3), only node7 active with criterio=17 -> pronto after 3 cycles, criterio=17, indice=7. The padded lanes of the last group must not win.
